// File: rtl/rosc_entropy_collector.sv
`default_nettype none
// ============================================================================
// rosc_entropy_collector
//   Pulls 32-bit words from an entropy source, packs NUM_WORDS of them into a
//   block and runs a repetition-count health test on the incoming words.
// Revision: 1.0
// ============================================================================
module rosc_entropy_collector #(
    parameter int NUM_WORDS    = 16,
    parameter int REPEAT_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      entropy_enabled,
    input  logic [31:0]               entropy_data,
    input  logic                      entropy_valid,
    output logic                      entropy_ack,
    output logic [32*NUM_WORDS-1:0]   block_data,
    output logic                      block_valid,
    input  logic                      block_ack,
    output logic                      repeat_error,
    output logic [7:0]                word_count
);

    localparam int             BW      = 32 * NUM_WORDS;
    localparam int             CW      = $clog2(REPEAT_LIMIT + 1);
    localparam logic [7:0]     C_LAST  = 8'(NUM_WORDS - 1);
    localparam logic [CW-1:0]  C_LIMIT = CW'(REPEAT_LIMIT);
    localparam logic [CW-1:0]  C_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WAIT    = 3'd2,
        S_FULL    = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_ack;
    logic            r_block_valid;
    logic            r_repeat_error;
    logic            r_have_prev;
    logic [BW-1:0]   r_block;
    logic [7:0]      r_word_count;
    logic [CW-1:0]   r_rep_cnt;
    logic [31:0]     r_last_word;

    logic            w_capture;
    logic            w_hit_limit;
    logic            w_block_done;
    logic [CW-1:0]   w_rep_next;

    // A low enable overrides every capture and block handoff.
    assign w_capture    = enable && (r_state == S_COLLECT) && entropy_enabled && entropy_valid;
    assign w_rep_next   = (r_have_prev && (entropy_data == r_last_word)) ? (r_rep_cnt + C_ONE) : C_ONE;
    assign w_hit_limit  = (w_rep_next >= C_LIMIT);
    assign w_block_done = (r_word_count == C_LAST);

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_state_next = S_COLLECT;
                S_COLLECT: begin
                    if (w_capture) begin
                        if (w_hit_limit)       w_state_next = S_ERROR;
                        else if (w_block_done) w_state_next = S_FULL;
                        else                   w_state_next = S_WAIT;
                    end
                end
                S_WAIT:    w_state_next = S_COLLECT;
                S_FULL:    if (block_ack) w_state_next = S_COLLECT;
                S_ERROR:   w_state_next = S_ERROR;
                default:   w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack          <= 1'b0;
            r_block        <= '0;
            r_block_valid  <= 1'b0;
            r_repeat_error <= 1'b0;
            r_word_count   <= 8'd0;
            r_rep_cnt      <= '0;
            r_last_word    <= 32'd0;
            r_have_prev    <= 1'b0;
        end else if (!enable) begin
            r_ack          <= 1'b0;
            r_block        <= '0;
            r_block_valid  <= 1'b0;
            r_repeat_error <= 1'b0;
            r_word_count   <= 8'd0;
            r_rep_cnt      <= '0;
            r_have_prev    <= 1'b0;
        end else begin
            r_ack <= w_capture;
            case (r_state)
                S_IDLE: begin
                    r_rep_cnt   <= '0;
                    r_have_prev <= 1'b0;
                end
                S_COLLECT: begin
                    if (w_capture) begin
                        r_block      <= {r_block[BW-33:0], entropy_data};
                        r_word_count <= r_word_count + 8'd1;
                        r_rep_cnt    <= w_rep_next;
                        r_last_word  <= entropy_data;
                        r_have_prev  <= 1'b1;
                        // A failing word is still acked but never completes a block.
                        if (w_hit_limit)       r_repeat_error <= 1'b1;
                        else if (w_block_done) r_block_valid  <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (block_ack) begin
                        r_block_valid <= 1'b0;
                        r_word_count  <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign entropy_ack  = r_ack;
    assign block_data   = r_block;
    assign block_valid  = r_block_valid;
    assign repeat_error = r_repeat_error;
    assign word_count   = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_rosc_entropy_collector.sv
`default_nettype none
// ============================================================================
// tb_rosc_entropy_collector
//   Directed self-checking bench for the entropy collector.
// Revision: 1.0
// ============================================================================
module tb_rosc_entropy_collector;

    localparam int NW = 16;
    localparam int BW = 32 * NW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          entropy_enabled;
    logic [31:0]   entropy_data;
    logic          entropy_valid;
    logic          entropy_ack;
    logic [BW-1:0] block_data;
    logic          block_valid;
    logic          block_ack;
    logic          repeat_error;
    logic [7:0]    word_count;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_cnt = 0;
    int cyc = 0;
    logic        src_inc = 1'b1;
    logic [31:0] src_word = 32'd0;

    rosc_entropy_collector #(.NUM_WORDS(NW), .REPEAT_LIMIT(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .entropy_enabled (entropy_enabled),
        .entropy_data    (entropy_data),
        .entropy_valid   (entropy_valid),
        .entropy_ack     (entropy_ack),
        .block_data      (block_data),
        .block_valid     (block_valid),
        .block_ack       (block_ack),
        .repeat_error    (repeat_error),
        .word_count      (word_count)
    );

    always #5 clk = ~clk;

    // Expected block for consecutive words first, first+1, ...; first word in MSBs.
    function automatic logic [BW-1:0] mk_block(input logic [31:0] first);
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < NW; k++) b = {b[BW-33:0], first + 32'(k)};
        return b;
    endfunction

    // One clock, sampled 1 time unit after the edge; the source advances on ack.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (entropy_ack) begin
            ack_cnt++;
            if (src_inc) begin
                src_word     = src_word + 32'd1;
                entropy_data = src_word;
            end
        end
    endtask

    task automatic restart(input logic [31:0] first, input logic inc);
        enable       = 1'b0;
        src_inc      = inc;
        src_word     = first;
        entropy_data = first;
        tick();
        ack_cnt = 0;
        enable  = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (entropy_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", entropy_ack); end
        n_cmp++; if (block_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", block_data); end
        n_cmp++; if (block_valid !== 1'b0) begin n_bad++; $display("FAIL reset_bvalid: got %b want 0", block_valid); end
        n_cmp++; if (repeat_error !== 1'b0) begin n_bad++; $display("FAIL reset_rerr: got %b want 0", repeat_error); end
        n_cmp++; if (word_count !== 8'd0) begin n_bad++; $display("FAIL reset_wcnt: got %0d want 0", word_count); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_stream();
        int last_ack;
        int gaps;
        logic [BW-1:0] exp_blk;
        last_ack = -1;
        gaps     = 0;
        restart(32'd1, 1'b1);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (entropy_ack) begin
                if (last_ack >= 0 && cyc - last_ack != 2) gaps++;
                last_ack = cyc;
            end
            if (block_valid) break;
        end
        exp_blk = mk_block(32'd1);
        n_cmp++; if (block_valid !== 1'b1) begin n_bad++; $display("FAIL stream_bvalid: got %b want 1 (timeout)", block_valid); end
        n_cmp++; if (ack_cnt != 16) begin n_bad++; $display("FAIL stream_acks: got %0d want 16", ack_cnt); end
        n_cmp++; if (entropy_ack !== 1'b1) begin n_bad++; $display("FAIL stream_last_ack_with_bvalid: got %b want 1", entropy_ack); end
        n_cmp++; if (gaps != 0) begin n_bad++; $display("FAIL stream_ack_spacing: got %0d bad gaps want 0", gaps); end
        n_cmp++; if (block_data[BW-1 -: 32] !== 32'h1) begin n_bad++; $display("FAIL stream_msw: got %h want 00000001", block_data[BW-1 -: 32]); end
        n_cmp++; if (block_data[31:0] !== 32'h10) begin n_bad++; $display("FAIL stream_lsw: got %h want 00000010", block_data[31:0]); end
        n_cmp++; if (block_data !== exp_blk) begin n_bad++; $display("FAIL stream_block: got %h want %h", block_data, exp_blk); end
        n_cmp++; if (word_count !== 8'd16) begin n_bad++; $display("FAIL stream_wcnt: got %0d want 16", word_count); end
        n_cmp++; if (repeat_error !== 1'b0) begin n_bad++; $display("FAIL stream_rerr: got %b want 0", repeat_error); end
    endtask

    task automatic test_hold_full();
        logic [BW-1:0] held;
        int acks0;
        int unstable;
        held     = block_data;
        acks0    = ack_cnt;
        unstable = 0;
        repeat (20) begin
            tick();
            if (block_data !== held || block_valid !== 1'b1) unstable++;
        end
        n_cmp++; if (ack_cnt != acks0) begin n_bad++; $display("FAIL hold_acks: got %0d want %0d", ack_cnt, acks0); end
        n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable); end
        block_ack = 1'b1;
        tick();
        block_ack = 1'b0;
        n_cmp++; if (block_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release_bvalid: got %b want 0", block_valid); end
        n_cmp++; if (word_count !== 8'd0) begin n_bad++; $display("FAIL hold_release_wcnt: got %0d want 0", word_count); end
        tick();
        n_cmp++; if (entropy_ack !== 1'b1) begin n_bad++; $display("FAIL hold_resume_ack: got %b want 1", entropy_ack); end
        n_cmp++; if (word_count !== 8'd1) begin n_bad++; $display("FAIL hold_resume_wcnt: got %0d want 1", word_count); end
        n_cmp++; if (block_data[31:0] !== 32'h11) begin n_bad++; $display("FAIL hold_resume_word: got %h want 00000011", block_data[31:0]); end
    endtask

    task automatic test_repeat();
        int err_at;
        logic err_ack;
        logic bv_seen;
        err_at  = -1;
        err_ack = 1'b0;
        bv_seen = 1'b0;
        restart(32'haa55aa55, 1'b0);
        repeat (40) begin
            tick();
            if (block_valid) bv_seen = 1'b1;
            if (repeat_error && err_at < 0) begin
                err_at  = ack_cnt;
                err_ack = entropy_ack;
            end
        end
        n_cmp++; if (err_at != 4) begin n_bad++; $display("FAIL repeat_err_at: got ack %0d want 4", err_at); end
        n_cmp++; if (err_ack !== 1'b1) begin n_bad++; $display("FAIL repeat_err_with_ack: got %b want 1", err_ack); end
        n_cmp++; if (ack_cnt != 4) begin n_bad++; $display("FAIL repeat_total_acks: got %0d want 4", ack_cnt); end
        n_cmp++; if (bv_seen !== 1'b0) begin n_bad++; $display("FAIL repeat_bvalid: got %b want 0", bv_seen); end
        n_cmp++; if (repeat_error !== 1'b1) begin n_bad++; $display("FAIL repeat_sticky: got %b want 1", repeat_error); end
        enable = 1'b0;
        tick();
        n_cmp++; if (repeat_error !== 1'b0) begin n_bad++; $display("FAIL repeat_clear: got %b want 0", repeat_error); end
        n_cmp++; if (word_count !== 8'd0) begin n_bad++; $display("FAIL repeat_clear_wcnt: got %0d want 0", word_count); end
        enable = 1'b1;
        tick();
        n_cmp++; if (repeat_error !== 1'b0) begin n_bad++; $display("FAIL repeat_reenable: got %b want 0", repeat_error); end
    endtask

    task automatic test_stall();
        logic [31:0] pat;
        logic cap_ok;
        int viol;
        logic [BW-1:0] exp_blk;
        pat  = 32'hB5A36C9D;
        viol = 0;
        restart(32'h100, 1'b1);
        for (int i = 0; i < 300; i++) begin
            entropy_valid   = pat[i % 32];
            entropy_enabled = !(i >= 10 && i < 20);
            cap_ok = entropy_valid & entropy_enabled;
            tick();
            if (entropy_ack && !cap_ok) viol++;
            if (block_valid) break;
        end
        entropy_valid   = 1'b1;
        entropy_enabled = 1'b1;
        exp_blk = mk_block(32'h100);
        n_cmp++; if (block_valid !== 1'b1) begin n_bad++; $display("FAIL stall_bvalid: got %b want 1 (timeout)", block_valid); end
        n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL stall_ack_when_low: got %0d want 0", viol); end
        n_cmp++; if (ack_cnt != 16) begin n_bad++; $display("FAIL stall_acks: got %0d want 16", ack_cnt); end
        n_cmp++; if (block_data !== exp_blk) begin n_bad++; $display("FAIL stall_block: got %h want %h", block_data, exp_blk); end
    endtask

    task automatic test_abort();
        logic [BW-1:0] exp_blk;
        restart(32'h200, 1'b1);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ack_cnt == 7) break;
        end
        n_cmp++; if (word_count !== 8'd7) begin n_bad++; $display("FAIL abort_pre_wcnt: got %0d want 7", word_count); end
        tick();
        enable = 1'b0;
        tick();
        n_cmp++; if (entropy_ack !== 1'b0) begin n_bad++; $display("FAIL abort_ack: got %b want 0", entropy_ack); end
        n_cmp++; if (word_count !== 8'd0) begin n_bad++; $display("FAIL abort_wcnt: got %0d want 0", word_count); end
        n_cmp++; if (block_data !== '0) begin n_bad++; $display("FAIL abort_data: got %h want 0", block_data); end
        n_cmp++; if (ack_cnt != 7) begin n_bad++; $display("FAIL abort_no_capture: got %0d acks want 7", ack_cnt); end
        enable  = 1'b1;
        ack_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (block_valid) break;
        end
        exp_blk = mk_block(32'h207);
        n_cmp++; if (ack_cnt != 16) begin n_bad++; $display("FAIL abort_refill_acks: got %0d want 16", ack_cnt); end
        n_cmp++; if (block_data !== exp_blk) begin n_bad++; $display("FAIL abort_refill_block: got %h want %h", block_data, exp_blk); end
    endtask

    task automatic test_async_reset();
        block_ack = 1'b1;
        tick();
        block_ack = 1'b0;
        repeat (6) tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (word_count !== 8'd0) begin n_bad++; $display("FAIL areset_mid_wcnt: got %0d want 0", word_count); end
        n_cmp++; if (block_data !== '0) begin n_bad++; $display("FAIL areset_mid_data: got %h want 0", block_data); end
        n_cmp++; if (entropy_ack !== 1'b0) begin n_bad++; $display("FAIL areset_mid_ack: got %b want 0", entropy_ack); end
        @(negedge clk);
        reset_n = 1'b1;
        ack_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (block_valid) break;
        end
        n_cmp++; if (block_valid !== 1'b1) begin n_bad++; $display("FAIL areset_refill: got %b want 1 (timeout)", block_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (block_valid !== 1'b0) begin n_bad++; $display("FAIL areset_full_bvalid: got %b want 0", block_valid); end
        n_cmp++; if (block_data !== '0) begin n_bad++; $display("FAIL areset_full_data: got %h want 0", block_data); end
        n_cmp++; if (word_count !== 8'd0) begin n_bad++; $display("FAIL areset_full_wcnt: got %0d want 0", word_count); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n         = 1'b0;
        enable          = 1'b0;
        entropy_enabled = 1'b1;
        entropy_valid   = 1'b1;
        entropy_data    = 32'd0;
        block_ack       = 1'b0;
        test_reset();
        test_stream();
        test_hold_full();
        test_repeat();
        test_stall();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
